multdiv_seq: RTL and testbench
==============================

MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
REQ-001 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-002 Port clr, input, 1: reset, synchronous, active-high.
REQ-003 Port data_operandA, input, 32: signed two's-complement multiplicand or dividend.
REQ-004 Port data_operandB, input, 32: signed two's-complement multiplier or divisor.
REQ-005 Port ctrl_MULT, input, 1: start-multiply request, sampled on a clock edge.
REQ-006 Port ctrl_DIV, input, 1: start-divide request, sampled on a clock edge.
REQ-007 Port data_result, output, 32: low 32 bits of the product, or the quotient; feeds a downstream 32-bit result register.
REQ-008 Port data_exception, output, 1: overflow or divide-by-zero flag for the current result.
REQ-009 Port data_resultRDY, output, 1: result-valid strobe, one cycle wide.
REQ-010 The block has no parameters.

Function
REQ-011 The FSM states SHALL be IDLE, BUSY and DONE, with a 5-bit iteration counter.
REQ-012 In IDLE or DONE, a high ctrl_MULT or ctrl_DIV at edge k SHALL latch both operands and the op type, clear the counter and enter BUSY.
REQ-013 If ctrl_MULT and ctrl_DIV are both high at the same edge, the block SHALL perform a multiply.
REQ-014 In BUSY, ctrl_MULT, ctrl_DIV and operand changes SHALL be ignored; the operation uses the latched operands only.
REQ-015 Each BUSY edge SHALL perform one iteration: a radix-2 Booth add/sub plus shift for multiply, or a restoring shift/subtract on the operand magnitudes for divide.
REQ-016 After 32 iterations (edges k+1..k+32), the FSM SHALL enter DONE; data_resultRDY SHALL be 1 for exactly the cycle following edge k+32.
REQ-017 From DONE without a new request, the FSM SHALL return to IDLE on the next edge, dropping data_resultRDY to 0.
REQ-018 Multiply: data_result SHALL equal bits [31:0] of the signed 64-bit product.
REQ-019 Multiply: data_exception SHALL be 1 iff the product lies outside [-2^31, 2^31-1].
REQ-020 Divide: the quotient SHALL truncate toward zero; its sign is signA XOR signB; the remainder is discarded.
REQ-021 Divide by zero (B = 0 at start): the FSM SHALL go from IDLE to DONE at edge k+1, with data_result = 0 and data_exception = 1.
REQ-022 Divide 0x80000000 / 0xFFFFFFFF SHALL yield data_result = 0x80000000 and data_exception = 1, with normal 32-iteration latency.
REQ-023 data_result and data_exception SHALL update only on entry to DONE and hold their values until the next DONE or a reset.
REQ-024 A start request at the DONE-cycle edge SHALL be accepted, allowing back-to-back operations every 33 cycles.

Reset
REQ-025 clr high at an edge SHALL force IDLE, counter = 0, data_result = 0, data_exception = 0 and data_resultRDY = 0.
REQ-026 clr SHALL take priority over ctrl_MULT and ctrl_DIV at the same edge.
REQ-027 clr asserted mid-BUSY SHALL abort the operation with no data_resultRDY pulse.
REQ-028 clr asserted in DONE SHALL suppress the remainder of that cycle's pulse from the next edge onward.

Verification
REQ-029 MULT, A = 7, B = -3, pulse at edge k -> data_resultRDY = 1 only in the cycle after edge k+32; data_result = 0xFFFFFFEB; data_exception = 0.
REQ-030 MULT, A = 0x00010000, B = 0x00010000 -> data_result = 0x00000000, data_exception = 1.
REQ-031 DIV, A = -17, B = 5 -> data_result = 0xFFFFFFFD (-3), data_exception = 0, 32-cycle latency.
REQ-032 DIV, A = 42, B = 0 -> data_resultRDY = 1 in the cycle after edge k+1; data_result = 0; data_exception = 1.
REQ-033 Re-pulse ctrl_MULT and ctrl_DIV with new operands during BUSY -> result matches the original operands; exactly one data_resultRDY pulse.
REQ-034 Assert clr at edge k+10 of a multiply -> outputs go to 0 at that edge; no data_resultRDY pulse; a following DIV 100 / 10 returns 10.

Source files
------------

// File: rtl/multdiv_seq.sv
// -----------------------------------------------------------------------------
// multdiv_seq
//
// Sequential signed 32x32 multiplier / 32/32 divider sharing one control FSM.
//
// Ports
//   clk            : single clock, all state changes on the rising edge
//   clr            : synchronous active-high reset, wins over any request
//   data_operandA  : signed multiplicand / dividend
//   data_operandB  : signed multiplier / divisor
//   ctrl_MULT      : start-multiply request (wins if ctrl_DIV is also high)
//   ctrl_DIV       : start-divide request
//   data_result    : low 32 bits of the product, or the truncated quotient
//   data_exception : product overflow, quotient overflow or divide by zero
//   data_resultRDY : one-cycle strobe marking a fresh result
//
// Handshake: a request is accepted at any edge where the FSM is in IDLE or
// DONE and ctrl_MULT or ctrl_DIV is high; there is no back-pressure. Requests
// seen while BUSY are dropped. data_resultRDY is high for exactly the one
// cycle spent in DONE; data_result / data_exception are written on entry to
// DONE and hold until the next DONE entry or clr.
//
// Multiply: radix-2 Booth, one add/sub + arithmetic shift per BUSY edge on a
// {hi[32:0], lo[31:0], q_m1} register, 32 iterations.
// Divide: restoring shift/subtract on operand magnitudes, 32 iterations, then
// the sign is applied to the quotient. A zero divisor finishes after one edge.
// -----------------------------------------------------------------------------
module multdiv_seq (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  count;
    logic        op_div;
    logic        div_by_zero;

    // Booth multiply working registers. hi carries one guard bit so the
    // add/sub of a sign-extended -2^31 multiplicand cannot overflow.
    logic [32:0] m_hi;
    logic [31:0] m_lo;
    logic        m_qm1;
    logic [32:0] m_mcand;

    // Restoring divide working registers (unsigned magnitudes).
    logic [31:0] d_rem;
    logic [31:0] d_quo;
    logic [31:0] d_mag_b;
    logic        d_neg;

    // Next-iteration values and final-result decode.
    logic [32:0] booth_sum;
    logic [32:0] m_hi_nx;
    logic [31:0] m_lo_nx;
    logic        m_qm1_nx;
    logic [63:0] product_nx;
    logic        mul_ovf;

    logic [32:0] d_shift;
    logic [32:0] d_diff;
    logic [31:0] d_rem_nx;
    logic [31:0] d_quo_nx;
    logic [31:0] quo_signed;
    logic        div_ovf;

    logic        start;
    logic        start_div;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    always_comb begin
        start     = (state != BUSY) && (ctrl_MULT || ctrl_DIV);
        start_div = ctrl_DIV && !ctrl_MULT;

        // Negating 0x80000000 gives 0x80000000, which is the correct
        // unsigned magnitude 2^31.
        mag_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
        mag_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

        // Booth step: inspect {lo[0], q_m1}.
        booth_sum = m_hi;
        case ({m_lo[0], m_qm1})
            2'b01:   booth_sum = m_hi + m_mcand;
            2'b10:   booth_sum = m_hi - m_mcand;
            default: booth_sum = m_hi;
        endcase
        m_hi_nx    = {booth_sum[32], booth_sum[32:1]};
        m_lo_nx    = {booth_sum[0], m_lo[31:1]};
        m_qm1_nx   = m_lo[0];
        product_nx = {m_hi_nx[31:0], m_lo_nx};
        // Fits in 32 signed bits only if bits [63:31] are all equal.
        mul_ovf    = !((&product_nx[63:31]) || (~|product_nx[63:31]));

        // Restoring step. The partial remainder stays below the divisor
        // (<= 2^31), so the shifted value fits in 32 bits and bit 32 of the
        // difference is a reliable borrow.
        d_shift = {d_rem, d_quo[31]};
        d_diff  = d_shift - {1'b0, d_mag_b};
        if (!d_diff[32]) begin
            d_rem_nx = d_diff[31:0];
            d_quo_nx = {d_quo[30:0], 1'b1};
        end else begin
            d_rem_nx = d_shift[31:0];
            d_quo_nx = {d_quo[30:0], 1'b0};
        end
        quo_signed = d_neg ? (~d_quo_nx + 32'd1) : d_quo_nx;
        // Only a positive quotient of magnitude 2^31 (0x80000000 / -1)
        // is unrepresentable; its low 32 bits are still 0x80000000.
        div_ovf    = !d_neg && d_quo_nx[31];
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state          <= IDLE;
            count          <= 5'd0;
            op_div         <= 1'b0;
            div_by_zero    <= 1'b0;
            m_hi           <= 33'd0;
            m_lo           <= 32'd0;
            m_qm1          <= 1'b0;
            m_mcand        <= 33'd0;
            d_rem          <= 32'd0;
            d_quo          <= 32'd0;
            d_mag_b        <= 32'd0;
            d_neg          <= 1'b0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    data_resultRDY <= 1'b0;
                    if (start) begin
                        state       <= BUSY;
                        count       <= 5'd0;
                        op_div      <= start_div;
                        div_by_zero <= (data_operandB == 32'd0);
                        m_hi        <= 33'd0;
                        m_lo        <= data_operandB;
                        m_qm1       <= 1'b0;
                        m_mcand     <= {data_operandA[31], data_operandA};
                        d_rem       <= 32'd0;
                        d_quo       <= mag_a;
                        d_mag_b     <= mag_b;
                        d_neg       <= data_operandA[31] ^ data_operandB[31];
                    end else begin
                        state <= IDLE;
                    end
                end

                BUSY: begin
                    if (op_div && div_by_zero) begin
                        state          <= DONE;
                        data_result    <= 32'd0;
                        data_exception <= 1'b1;
                        data_resultRDY <= 1'b1;
                    end else begin
                        count <= count + 5'd1;
                        if (op_div) begin
                            d_rem <= d_rem_nx;
                            d_quo <= d_quo_nx;
                        end else begin
                            m_hi  <= m_hi_nx;
                            m_lo  <= m_lo_nx;
                            m_qm1 <= m_qm1_nx;
                        end
                        // count == 31 means this edge performs iteration 32.
                        if (count == 5'd31) begin
                            state          <= DONE;
                            data_resultRDY <= 1'b1;
                            if (op_div) begin
                                data_result    <= quo_signed;
                                data_exception <= div_ovf;
                            end else begin
                                data_result    <= product_nx[31:0];
                                data_exception <= mul_ovf;
                            end
                        end
                    end
                end

                default: begin
                    state          <= IDLE;
                    data_resultRDY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_seq.sv
// -----------------------------------------------------------------------------
// tb_multdiv_seq
//
// Bench for multdiv_seq: a directed vector table, hand-written sequences for
// busy-time request filtering, clr behaviour and back-to-back operation, then
// randomized operations scored against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_multdiv_seq;

    logic        clk;
    logic        clr;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_total = 0;
    int n_pass  = 0;

    logic [32:0] exp_q[$];

    multdiv_seq dut (
        .clk           (clk),
        .clr           (clr),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
    endtask

    // Reference model straight from the arithmetic definition.
    function automatic void model(input logic m, input logic d, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic e);
        longint p;
        longint q;
        longint lim;
        lim = 64'sd2147483647;
        if (m || !d) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p > lim) || (p < -lim - 64'sd1);
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = q[31:0];
            e = (q > lim);
        end
    endfunction

    // ---------------- drivers ----------------
    // Called just after the request edge k; returns at the negedge following
    // the first edge that raises data_resultRDY (lat = n for edge k+n).
    task automatic wait_rdy(output int lat, output logic [31:0] r, output logic e);
        lat = -1;
        r   = 32'd0;
        e   = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (data_resultRDY) begin
                lat = n;
                r   = data_result;
                e   = data_exception;
                break;
            end
        end
    endtask

    task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] r,
                          output logic e, output int lat);
        @(negedge clk);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(negedge clk);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        // Scramble operands to confirm the latched copies are used.
        data_operandA = $urandom;
        data_operandB = $urandom;
        wait_rdy(lat, r, e);
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (data_resultRDY) pulses++;
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        string       name;
        logic        m;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] r;
        logic        e;
        int          lat;
        int          pulses;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rm;
        logic        rd;
        logic [31:0] mr;
        logic        me;
        logic [32:0] expv;

        vecs[0]  = '{"mul_7_m3",      1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 32};
        vecs[1]  = '{"mul_ovf_2p32",  1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 32};
        vecs[2]  = '{"div_m17_5",     1'b0, 1'b1, 32'hFFFFFFEF, 32'd5,        32'hFFFFFFFD, 1'b0, 32};
        vecs[3]  = '{"div_42_0",      1'b0, 1'b1, 32'd42,       32'd0,        32'h00000000, 1'b1, 1};
        vecs[4]  = '{"div_min_m1",    1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 32};
        vecs[5]  = '{"mul_min_m1",    1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 32};
        vecs[6]  = '{"mul_min_1",     1'b1, 1'b0, 32'h80000000, 32'd1,        32'h80000000, 1'b0, 32};
        vecs[7]  = '{"div_7_m2",      1'b0, 1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 32};
        vecs[8]  = '{"both_6_3",      1'b1, 1'b1, 32'd6,        32'd3,        32'h00000012, 1'b0, 32};
        vecs[9]  = '{"div_min_1",     1'b0, 1'b1, 32'h80000000, 32'd1,        32'h80000000, 1'b0, 32};
        vecs[10] = '{"mul_m1_m1",     1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32};
        vecs[11] = '{"div_m1_7",      1'b0, 1'b1, 32'hFFFFFFFF, 32'd7,        32'h00000000, 1'b0, 32};

        // ---------------- reset ----------------
        clr           = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_result", data_result, 32'd0);
        check("reset_exc", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        clr = 1'b0;

        // ---------------- directed table ----------------
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b, r, e, lat);
            check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            check({vecs[i].name, "_res"}, r, vecs[i].res);
            check({vecs[i].name, "_exc"}, {31'd0, e}, {31'd0, vecs[i].exc});
            @(negedge clk);
            check({vecs[i].name, "_rdy_drop"}, {31'd0, data_resultRDY}, 32'd0);
            check({vecs[i].name, "_hold"}, data_result, vecs[i].res);
        end

        // ---------------- back-to-back at the DONE edge ----------------
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, r, e, lat);
        check("b2b_first_lat", lat, 32);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'hFFFFFFEF;
        data_operandB = 32'd5;
        @(negedge clk);
        ctrl_DIV = 1'b0;
        check("b2b_rdy_low", {31'd0, data_resultRDY}, 32'd0);
        check("b2b_hold", data_result, 32'hFFFFFFEB);
        wait_rdy(lat, r, e);
        check("b2b_second_lat", lat, 32);
        check("b2b_second_res", r, 32'hFFFFFFFD);

        // ---------------- requests during BUSY are ignored ----------------
        @(negedge clk);
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd7;
        data_operandB = 32'hFFFFFFFD;
        @(negedge clk);
        ctrl_MULT = 1'b0;
        pulses = 0;
        lat    = -1;
        r      = 32'd0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (n >= 3 && n <= 8) begin
                ctrl_MULT     = 1'($urandom);
                ctrl_DIV      = 1'($urandom);
                data_operandA = $urandom;
                data_operandB = $urandom;
            end else begin
                ctrl_MULT = 1'b0;
                ctrl_DIV  = 1'b0;
            end
            if (data_resultRDY) begin
                pulses++;
                lat = n;
                r   = data_result;
            end
        end
        check("busy_ignore_pulses", pulses, 1);
        check("busy_ignore_lat", lat, 32);
        check("busy_ignore_res", r, 32'hFFFFFFEB);

        // ---------------- clr at edge k+10 of a multiply ----------------
        @(negedge clk);
        ctrl_MULT     = 1'b1;
        data_operandA = 32'h00001234;
        data_operandB = 32'h00005678;
        @(negedge clk);
        ctrl_MULT = 1'b0;
        for (int n = 1; n <= 9; n++) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("abort_res", data_result, 32'd0);
        check("abort_exc", {31'd0, data_exception}, 32'd0);
        check("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
        count_pulses(40, pulses);
        check("abort_no_pulse", pulses, 0);
        run_op(1'b0, 1'b1, 32'd100, 32'd10, r, e, lat);
        check("abort_then_div_lat", lat, 32);
        check("abort_then_div_res", r, 32'd10);

        // ---------------- clr in DONE ----------------
        run_op(1'b1, 1'b0, 32'h00010000, 32'h00010000, r, e, lat);
        check("done_clr_exc_before", {31'd0, e}, 32'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("done_clr_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("done_clr_res", data_result, 32'd0);
        check("done_clr_exc", {31'd0, data_exception}, 32'd0);

        // ---------------- clr beats a simultaneous request ----------------
        @(negedge clk);
        clr           = 1'b1;
        ctrl_MULT     = 1'b1;
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd3;
        @(negedge clk);
        clr       = 1'b0;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        count_pulses(40, pulses);
        check("clr_priority_no_pulse", pulses, 0);

        // ---------------- randomized vs. reference model ----------------
        for (int i = 0; i < 24; i++) begin
            rm = 1'($urandom);
            rd = !rm || (1'($urandom));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 20);
                2:       rb = -$urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 1000);
            model(rm, rd, ra, rb, mr, me);
            exp_q.push_back({me, mr});
            run_op(rm, rd, ra, rb, r, e, lat);
            expv = exp_q.pop_front();
            check($sformatf("rand%0d_res", i), r, expv[31:0]);
            check($sformatf("rand%0d_exc", i), {31'd0, e}, {31'd0, expv[32]});
            check($sformatf("rand%0d_lat", i), lat, (!rm && rb == 32'd0) ? 1 : 32);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
